// File: rtl/iob_regfile_streamer_pkg.sv
// rtl/iob_regfile_streamer_pkg.sv - shared state encoding and width helper for the register file streamer
package iob_regfile_streamer_pkg;

  // Sequencer states; encodings are fixed so debug dumps stay readable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Length and remaining-count registers need one extra bit so a full-file burst fits.
  function automatic int len_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/iob_regfile_streamer_oreg.sv
// rtl/iob_regfile_streamer_oreg.sv - stream output register with load/hold/clear
module iob_regfile_streamer_oreg
  import iob_regfile_streamer_pkg::*;
#(
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o
);

  // Clear beats load; with neither asserted the beat is held so a stalled consumer sees stable data.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (load_i) begin
      data_o  <= load_data_i;
      valid_o <= 1'b1;
      last_o  <= load_last_i;
    end
  end

endmodule

// File: rtl/iob_regfile_streamer.sv
// rtl/iob_regfile_streamer.sv - walks a register file address range and streams the words out
module iob_regfile_streamer
  import iob_regfile_streamer_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 21
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [ADDR_W:0]     len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   rf_addr_o,
  input  logic [DATA_W-1:0]   rf_r_data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                valid_o,
  output logic                last_o,
  input  logic                ready_i
);

  localparam int LEN_W = len_width(ADDR_W);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               load, clear, load_last;
  logic               fetch, xfer;

  // A fetch refills the output register whenever it is empty or being drained this cycle.
  assign fetch     = (state_q == ST_RUN) && (!valid_o || ready_i);
  assign xfer      = valid_o && ready_i;
  assign load_last = (rem_q == LEN_W'(1));

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign rf_addr_o = addr_q;

  // State, address and remaining-count registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output-register control; abort overrides everything and suppresses done.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              addr_d  = start_addr_i;
              rem_d   = len_i;
            end
          end
        end
        ST_RUN: begin
          if (fetch) begin
            load   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            if (load_last) begin
              state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (xfer) begin
            clear   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  iob_regfile_streamer_oreg #(
    .DATA_W (DATA_W)
  ) u_oreg (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .load_i      (load),
    .clear_i     (clear),
    .load_data_i (rf_r_data_i),
    .load_last_i (load_last),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .last_o      (last_o)
  );

endmodule

// File: tb/tb_iob_regfile_streamer.sv
// tb/tb_iob_regfile_streamer.sv - directed self-checking bench for iob_regfile_streamer
module tb_iob_regfile_streamer;

  localparam logic [20:0] W_A = 21'h1A0A0A;
  localparam logic [20:0] W_B = 21'h0B1B1B;
  localparam logic [20:0] W_C = 21'h1C2C2C;
  localparam logic [20:0] W_D = 21'h0D3D3D;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        start_i;
  logic        abort_i;
  logic [1:0]  start_addr_i;
  logic [2:0]  len_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  rf_addr_o;
  logic [20:0] rf_r_data_i;
  logic [20:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;

  logic [20:0] mem [4];
  int          n_checks = 0;
  int          n_errors = 0;

  assign rf_r_data_i = mem[rf_addr_o];

  always #5 clk_i = ~clk_i;

  iob_regfile_streamer #(
    .ADDR_W (2),
    .DATA_W (21)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .start_addr_i (start_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rf_addr_o    (rf_addr_o),
    .rf_r_data_i  (rf_r_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .ready_i      (ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_burst(input string tag, input logic [1:0] a, input logic [2:0] n,
                           input logic [20:0] exp [4]);
    int beats = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    int last_at = -1;
    int last_cnt = 0;
    ready_i      = 1'b1;
    start_i      = 1'b1;
    start_addr_i = a;
    len_i        = n;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (valid_o && ready_i) begin
        if (beats < 4) check({tag, "_data"}, 32'(data_o), 32'(exp[beats]));
        if (last_o) begin
          last_at = beats;
          last_cnt++;
        end
        beats++;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        done_at = c;
      end
      tick();
    end
    check({tag, "_beats"},    32'(beats),    32'(n));
    check({tag, "_busy_cyc"}, 32'(busy_cnt), (n == 0) ? 32'd0 : 32'(n) + 32'd1);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"},  32'(done_at),  (n == 0) ? 32'd0 : 32'(n) + 32'd1);
    check({tag, "_last_at"},  32'(last_at),  (n == 0) ? 32'hFFFF_FFFF : 32'(n) - 32'd1);
    check({tag, "_last_cnt"}, 32'(last_cnt), (n == 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [20:0] e [4];
    logic [3:0]  pat;
    int          beats;
    int          done_cnt;
    logic        hold_pend;
    logic [20:0] hold_data;
    logic        hold_last;

    mem[0] = W_A;
    mem[1] = W_B;
    mem[2] = W_C;
    mem[3] = W_D;
    arst_n_i     = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    start_addr_i = '0;
    len_i        = '0;
    ready_i      = 1'b1;
    #12;
    check("rst_busy",  32'(busy_o),    32'd0);
    check("rst_done",  32'(done_o),    32'd0);
    check("rst_valid", 32'(valid_o),   32'd0);
    check("rst_last",  32'(last_o),    32'd0);
    check("rst_data",  32'(data_o),    32'd0);
    check("rst_addr",  32'(rf_addr_o), 32'd0);
    arst_n_i = 1'b1;
    tick();

    e = '{W_B, W_C, W_D, 21'h0};
    run_burst("b1_a1_l3", 2'd1, 3'd3, e);

    e = '{W_D, W_A, W_B, W_C};
    run_burst("b2_wrap", 2'd3, 3'd4, e);

    e = '{21'h0, 21'h0, 21'h0, 21'h0};
    run_burst("b3_len0", 2'd2, 3'd0, e);

    // Stalled consumer: ready pattern 1,0,0,1 repeating.
    pat          = 4'b1001;
    beats        = 0;
    done_cnt     = 0;
    hold_pend    = 1'b0;
    hold_data    = '0;
    hold_last    = 1'b0;
    e            = '{W_A, W_B, W_C, W_D};
    start_i      = 1'b1;
    start_addr_i = 2'd0;
    len_i        = 3'd4;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ready_i = pat[c % 4];
      if (hold_pend) begin
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_data",  32'(data_o),  32'(hold_data));
        check("stall_last",  32'(last_o),  32'(hold_last));
      end
      hold_pend = valid_o && !ready_i;
      hold_data = data_o;
      hold_last = last_o;
      if (valid_o && ready_i) begin
        if (beats < 4) check("stall_beat", 32'(data_o), 32'(e[beats]));
        check("stall_beat_last", 32'(last_o), (beats == 3) ? 32'd1 : 32'd0);
        beats++;
      end
      if (done_o) done_cnt++;
      tick();
    end
    check("stall_beats", 32'(beats),    32'd4);
    check("stall_done",  32'(done_cnt), 32'd1);
    ready_i = 1'b1;

    // Abort in the cycle after the second accepted beat.
    start_i      = 1'b1;
    start_addr_i = 2'd0;
    len_i        = 3'd4;
    tick();
    start_i = 1'b0;
    tick();
    check("ab_beat1", 32'(data_o), 32'(W_A));
    tick();
    check("ab_beat2", 32'(data_o), 32'(W_B));
    tick();
    check("ab_beat3_valid", 32'(valid_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("ab_valid", 32'(valid_o), 32'd0);
    check("ab_last",  32'(last_o),  32'd0);
    check("ab_busy",  32'(busy_o),  32'd0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_o || valid_o) done_cnt++;
      tick();
    end
    check("ab_no_done", 32'(done_cnt), 32'd0);
    e = '{W_C, W_D, 21'h0, 21'h0};
    run_burst("ab_restart", 2'd2, 3'd2, e);

    // Asynchronous reset in the middle of a burst.
    start_i      = 1'b1;
    start_addr_i = 2'd1;
    len_i        = 3'd4;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #2;
    arst_n_i = 1'b0;
    #1;
    check("ar_busy",  32'(busy_o),    32'd0);
    check("ar_valid", 32'(valid_o),   32'd0);
    check("ar_last",  32'(last_o),    32'd0);
    check("ar_data",  32'(data_o),    32'd0);
    check("ar_addr",  32'(rf_addr_o), 32'd0);
    check("ar_done",  32'(done_o),    32'd0);
    tick();
    #2;
    arst_n_i = 1'b1;
    tick();
    check("ar_idle_valid", 32'(valid_o), 32'd0);
    e = '{W_B, W_C, W_D, 21'h0};
    run_burst("ar_restart", 2'd1, 3'd3, e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
